// File: rtl/memory_responder_if.sv
// rtl/memory_responder_if.sv - memory port bundle between datapath (master) and responder (slave)
interface memory_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  read;
  logic                  write;
  logic [31:0]           address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] Mdatain;
  logic                  done;
  logic                  error;

  modport master (
    output read, write, address, data_in,
    input  Mdatain, done, error
  );

  modport slave (
    input  read, write, address, data_in,
    output Mdatain, done, error
  );
endinterface

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - word-addressed RAM with programmable wait states and req/done handshake
module memory_responder #(
  parameter int    DATA_WIDTH  = 32,
  parameter int    ADDR_BITS   = 9,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input logic                clock,
  input logic                clear,
  memory_responder_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  op_write;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] mdat_q;
  logic                  done_q;
  logic                  error_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                 in_range;
  logic [ADDR_BITS-1:0] idx;
  logic                 access_now;

  assign in_range   = (addr_q[31:ADDR_BITS] == '0);
  assign idx        = addr_q[ADDR_BITS-1:0];
  assign access_now = (state == BUSY) && (cnt == 4'd0);

  // Array has no reset: contents survive clear, but an aborted write never lands.
  always_ff @(posedge clock) begin
    if (!clear && access_now && op_write && in_range)
      mem[idx] <= data_q;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      op_write <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      mdat_q   <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q  <= 1'b0;
          error_q <= bus.read & bus.write;
          if (bus.read ^ bus.write) begin
            op_write <= bus.write;
            addr_q   <= bus.address;
            data_q   <= bus.data_in;
            cnt      <= 4'(WAIT_CYCLES);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state   <= DONE;
            done_q  <= 1'b1;
            error_q <= !in_range;
            if (!op_write)
              mdat_q <= in_range ? mem[idx] : '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // Strobes still high keep us here; no second access until they drop.
          if (!(bus.read | bus.write)) begin
            state   <= IDLE;
            done_q  <= 1'b0;
            error_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Mdatain = mdat_q;
  assign bus.done    = done_q;
  assign bus.error   = error_q;
endmodule
